if_stage: RTL and testbench
===========================

IF_STAGE -- requirements
Module: if_stage

Interface
REQ-001 Parameter RESET_PC, default 32'h0000_0000: PC value loaded on reset.
REQ-002 Parameter PC_STEP, default 4: byte increment per sequential fetch.
REQ-003 clk  input  1  rising-edge clock, single clock domain.
REQ-004 rst  input  1  reset, asynchronous, active-high.
REQ-005 freeze  input  1  hazard stall: hold PC and IF/ID register.
REQ-006 branch_taken  input  1  redirect fetch to branch_addr.
REQ-007 branch_addr  input  32  redirect target byte address.
REQ-008 flush  input  1  squash IF/ID contents without changing PC.
REQ-009 imem_addr  output  32  byte address to the instruction memory, equal to current PC.
REQ-010 imem_data  input  32  instruction word returned combinationally, same cycle.
REQ-011 pc_out  output  32  registered PC+4 of the instruction held in IF/ID.
REQ-012 instr_out  output  32  registered instruction word to the decode stage.
REQ-013 valid_out  output  1  high when instr_out is a real fetched instruction.

Function
REQ-014 imem_addr SHALL be driven combinationally from the PC register, with no added latency.
REQ-015 Normal cycle (no freeze, no branch_taken, no flush): PC <= PC+PC_STEP; IF/ID <= {PC+PC_STEP, imem_data, valid=1}.
REQ-016 Fetch-to-decode latency SHALL be exactly one clock.
REQ-017 branch_taken=1: PC <= {branch_addr[31:2], 2'b00}; IF/ID <= {0, 32'h0, valid=0} in the same edge.
REQ-018 branch_taken SHALL override freeze when both are high.
REQ-019 freeze=1 with branch_taken=0: PC and all IF/ID fields SHALL hold their values, including valid_out.
REQ-020 flush=1 with branch_taken=0 and freeze=0: PC advances per REQ-015 and IF/ID loads {0, 32'h0, valid=0}.
REQ-021 flush=1 with freeze=1 and branch_taken=0: flush wins for IF/ID (bubble inserted); PC holds.
REQ-022 PC increment SHALL wrap modulo 2^32: 32'hFFFF_FFFC + 4 -> 32'h0000_0000.
REQ-023 An all-zero imem_data word is a NOP and SHALL still be captured with valid=1.
REQ-024 Control priority, highest first: rst, branch_taken, flush, freeze, sequential advance.

Reset
REQ-025 On rst assertion, PC SHALL become RESET_PC immediately, without waiting for a clock edge.
REQ-026 On reset, pc_out=0, instr_out=32'h0, and valid_out=0.
REQ-027 Reset asserted mid-stall or mid-branch SHALL discard all pending state.
REQ-028 The first edge after rst release SHALL capture the instruction at RESET_PC.

Configuration
REQ-029 Macro IF_PERF_CNT_EN defined: add outputs fetch_cnt[31:0] and stall_cnt[31:0], both reset to 0.
REQ-030 fetch_cnt increments on every REQ-015 capture; stall_cnt increments on every freeze-hold cycle; both wrap at 2^32.
REQ-031 Macro undefined: both counters and their ports are absent; all other behaviour is identical.

Structure
REQ-032 Shared package: INSTR_W=32, ADDR_W=32, NOP_INSTR=32'h0, and the control-priority encoding constants.
REQ-033 One sub-module, pc_reg: the PC register with asynchronous reset, load enable, and redirect mux; IF/ID logic stays in if_stage.

Verification
REQ-034 Reset, then 4 free-running cycles with imem[i]=i+1 -> imem_addr 0,4,8,12; instr_out 1,2,3; pc_out 4,8,12; valid_out=1.
REQ-035 freeze high for 3 cycles at PC=8 -> imem_addr stays 8; instr_out and valid_out unchanged; stall_cnt=3 when IF_PERF_CNT_EN is defined.
REQ-036 branch_taken with branch_addr=32'h0000_0042 -> next imem_addr=0x40; following cycle valid_out=0 and instr_out=0; next fetch resumes at 0x44.
REQ-037 branch_taken and freeze together, target 0x100 -> PC=0x100 and bubble inserted.
REQ-038 PC forced to 0xFFFF_FFFC, one advance -> imem_addr=0; pc_out=0.
REQ-039 rst pulsed between clock edges during a freeze -> outputs reach reset values before the next edge; fetch restarts at RESET_PC.

Source files
------------

// File: rtl/if_stage_pkg.sv
// if_stage_pkg: shared widths, NOP encoding and fetch-control priority encoding
// Used by: if_stage, pc_reg (import if_stage_pkg::*)
package if_stage_pkg;
    localparam int INSTR_W = 32;
    localparam int ADDR_W  = 32;
    localparam logic [INSTR_W-1:0] NOP_INSTR = 32'h0;
    // Per-cycle fetch action.
    // Bit 1 set means that IF/ID loads a bubble this edge.
    localparam logic [1:0] CTL_ADV    = 2'd0;
    localparam logic [1:0] CTL_HOLD   = 2'd1;
    localparam logic [1:0] CTL_FLUSH  = 2'd2;
    localparam logic [1:0] CTL_BRANCH = 2'd3;
    // Priority, highest first: branch, flush, freeze, sequential advance.
    // Reset is handled separately, because it is asynchronous.
    function automatic logic [1:0] ctl_sel(input logic branch, input logic flush, input logic freeze);
        return branch ? CTL_BRANCH : flush ? CTL_FLUSH : freeze ? CTL_HOLD : CTL_ADV;
    endfunction
endpackage

// File: rtl/if_stage_if.sv
// if_stage_if: instruction-memory fetch bus
// Signals:
//   imem_addr - byte address, driven by the fetch stage
//   imem_data - instruction word, returned combinationally by the memory
// Modports: master (fetch stage), slave (instruction memory)
interface if_stage_if;
    import if_stage_pkg::*;
    logic [ADDR_W-1:0]  imem_addr;
    logic [INSTR_W-1:0] imem_data;
    modport master (output imem_addr, input imem_data);
    modport slave  (input imem_addr, output imem_data);
endinterface

// File: rtl/if_stage_pc_reg.sv
// pc_reg: program counter with asynchronous reset, load enable and redirect mux
// Ports:
//   clk, rst   - clock, asynchronous active-high reset (the PC loads RESET_PC)
//   i_load_en  - advance the PC by PC_STEP
//   i_redirect - load the word-aligned i_target; this overrides i_load_en
//   i_target   - redirect byte address
//   o_pc       - current PC
//   o_pc_inc   - PC + PC_STEP, which wraps modulo 2^ADDR_W
module pc_reg
    import if_stage_pkg::*;
#(
    parameter logic [ADDR_W-1:0] RESET_PC = '0,
    parameter int unsigned       PC_STEP  = 4
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              i_load_en,
    input  logic              i_redirect,
    input  logic [ADDR_W-1:0] i_target,
    output logic [ADDR_W-1:0] o_pc,
    output logic [ADDR_W-1:0] o_pc_inc
);
    logic [ADDR_W-1:0] r_pc;

    assign o_pc     = r_pc;
    assign o_pc_inc = r_pc + ADDR_W'(PC_STEP);

    always_ff @(posedge clk or posedge rst) begin
        if (rst)
            r_pc <= RESET_PC;
        else if (i_redirect)
            r_pc <= i_target & ~ADDR_W'(3);
        else if (i_load_en)
            r_pc <= o_pc_inc;
    end
endmodule

// File: rtl/if_stage.sv
// if_stage: instruction fetch stage with PC and IF/ID pipeline register
// Optional feature: define IF_PERF_CNT_EN to add the o_fetch_cnt and o_stall_cnt counters.
// Ports:
//   clk, rst        - clock, asynchronous active-high reset
//   i_freeze        - hazard stall: hold the PC and IF/ID
//   i_branch_taken  - redirect fetch to i_branch_addr and squash IF/ID
//   i_branch_addr   - redirect target byte address
//   i_flush         - squash IF/ID without changing the PC
//   imem            - fetch bus (master): imem_addr = PC, imem_data combinational
//   o_pc_out        - PC+PC_STEP of the instruction held in IF/ID
//   o_instr_out     - instruction word held in IF/ID
//   o_fetch_cnt     - (IF_PERF_CNT_EN) count of sequential captures
//   o_stall_cnt     - (IF_PERF_CNT_EN) count of freeze-hold cycles
//   o_valid_out     - IF/ID holds a real fetched instruction
module if_stage
    import if_stage_pkg::*;
#(
    parameter logic [ADDR_W-1:0] RESET_PC = 32'h0000_0000,
    parameter int unsigned       PC_STEP  = 4
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               i_freeze,
    input  logic               i_branch_taken,
    input  logic [ADDR_W-1:0]  i_branch_addr,
    input  logic               i_flush,
    if_stage_if.master         imem,
    output logic [ADDR_W-1:0]  o_pc_out,
    output logic [INSTR_W-1:0] o_instr_out,
`ifdef IF_PERF_CNT_EN
    output logic [31:0]        o_fetch_cnt,
    output logic [31:0]        o_stall_cnt,
`endif
    output logic               o_valid_out
);
    logic [1:0]        w_ctl;
    logic [ADDR_W-1:0] w_pc;
    logic [ADDR_W-1:0] w_pc_inc;

    assign w_ctl = ctl_sel(i_branch_taken, i_flush, i_freeze);

    // A flush alone still advances the PC.
    // Freeze holds the PC unless a branch redirects it.
    pc_reg #(
        .RESET_PC (RESET_PC),
        .PC_STEP  (PC_STEP)
    ) u_pc_reg (
        .clk        (clk),
        .rst        (rst),
        .i_load_en  (!i_freeze),
        .i_redirect (i_branch_taken),
        .i_target   (i_branch_addr),
        .o_pc       (w_pc),
        .o_pc_inc   (w_pc_inc)
    );

    assign imem.imem_addr = w_pc;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            o_pc_out    <= '0;
            o_instr_out <= NOP_INSTR;
            o_valid_out <= 1'b0;
        end else if (w_ctl[1]) begin
            o_pc_out    <= '0;
            o_instr_out <= NOP_INSTR;
            o_valid_out <= 1'b0;
        end else if (w_ctl == CTL_ADV) begin
            o_pc_out    <= w_pc_inc;
            o_instr_out <= imem.imem_data;
            o_valid_out <= 1'b1;
        end
    end

`ifdef IF_PERF_CNT_EN
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            o_fetch_cnt <= '0;
            o_stall_cnt <= '0;
        end else begin
            if (w_ctl == CTL_ADV)
                o_fetch_cnt <= o_fetch_cnt + 32'd1;
            if (w_ctl == CTL_HOLD)
                o_stall_cnt <= o_stall_cnt + 32'd1;
        end
    end
`endif
endmodule

// File: tb/tb_if_stage.sv
// tb_if_stage: directed table-driven testbench for if_stage
module tb_if_stage;
    typedef struct {
        logic        frz;
        logic        br;
        logic [31:0] baddr;
        logic        fl;
        logic [31:0] e_addr;
        logic [31:0] e_pc;
        logic [31:0] e_instr;
        logic        e_valid;
    } vec_t;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        freeze = 1'b0;
    logic        branch_taken = 1'b0;
    logic [31:0] branch_addr = '0;
    logic        flush = 1'b0;
    logic [31:0] pc_out;
    logic [31:0] instr_out;
    logic        valid_out;
`ifdef IF_PERF_CNT_EN
    logic [31:0] fetch_cnt;
    logic [31:0] stall_cnt;
`endif
    int total = 0;
    int bad = 0;
    vec_t v[21];

    if_stage_if imem_bus();

    // The word at byte address 0x50 is a NOP.
    // Every other word is its word index + 1.
    assign imem_bus.imem_data = (imem_bus.imem_addr == 32'h50) ? 32'h0 : (imem_bus.imem_addr >> 2) + 32'd1;

    if_stage dut (
        .clk            (clk),
        .rst            (rst),
        .i_freeze       (freeze),
        .i_branch_taken (branch_taken),
        .i_branch_addr  (branch_addr),
        .i_flush        (flush),
        .imem           (imem_bus),
        .o_pc_out       (pc_out),
        .o_instr_out    (instr_out),
`ifdef IF_PERF_CNT_EN
        .o_fetch_cnt    (fetch_cnt),
        .o_stall_cnt    (stall_cnt),
`endif
        .o_valid_out    (valid_out)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic chk_all(input string tag, input logic [31:0] a, input logic [31:0] p, input logic [31:0] ins, input logic val);
        chk({tag, " imem_addr"}, imem_bus.imem_addr, a);
        chk({tag, " pc_out"}, pc_out, p);
        chk({tag, " instr_out"}, instr_out, ins);
        chk({tag, " valid_out"}, {31'b0, valid_out}, {31'b0, val});
    endtask

    function automatic vec_t mk(logic frz, logic br, logic [31:0] ba, logic fl, logic [31:0] a, logic [31:0] p, logic [31:0] ins, logic val);
        vec_t r;
        r.frz = frz;
        r.br = br;
        r.baddr = ba;
        r.fl = fl;
        r.e_addr = a;
        r.e_pc = p;
        r.e_instr = ins;
        r.e_valid = val;
        return r;
    endfunction

    initial begin
        // Columns: freeze, branch, branch_addr, flush ->
        // expected imem_addr, pc_out, instr_out, valid_out.
        v[0]  = mk(0, 0, 0, 0, 32'h04, 32'h04, 32'd1, 1);
        v[1]  = mk(0, 0, 0, 0, 32'h08, 32'h08, 32'd2, 1);
        v[2]  = mk(1, 0, 0, 0, 32'h08, 32'h08, 32'd2, 1);
        v[3]  = mk(1, 0, 0, 0, 32'h08, 32'h08, 32'd2, 1);
        v[4]  = mk(1, 0, 0, 0, 32'h08, 32'h08, 32'd2, 1);
        v[5]  = mk(0, 0, 0, 0, 32'h0C, 32'h0C, 32'd3, 1);
        v[6]  = mk(0, 0, 0, 0, 32'h10, 32'h10, 32'd4, 1);
        v[7]  = mk(0, 1, 32'h42, 0, 32'h40, 32'h0, 32'h0, 0);
        v[8]  = mk(0, 0, 0, 0, 32'h44, 32'h44, 32'd17, 1);
        v[9]  = mk(0, 0, 0, 0, 32'h48, 32'h48, 32'd18, 1);
        v[10] = mk(0, 0, 0, 1, 32'h4C, 32'h0, 32'h0, 0);
        v[11] = mk(0, 0, 0, 0, 32'h50, 32'h50, 32'd20, 1);
        v[12] = mk(0, 0, 0, 0, 32'h54, 32'h54, 32'h0, 1);
        v[13] = mk(1, 0, 0, 1, 32'h54, 32'h0, 32'h0, 0);
        v[14] = mk(1, 0, 0, 0, 32'h54, 32'h0, 32'h0, 0);
        v[15] = mk(0, 0, 0, 0, 32'h58, 32'h58, 32'd22, 1);
        v[16] = mk(1, 1, 32'h100, 0, 32'h100, 32'h0, 32'h0, 0);
        v[17] = mk(0, 0, 0, 0, 32'h104, 32'h104, 32'h41, 1);
        v[18] = mk(0, 1, 32'hFFFF_FFFC, 1, 32'hFFFF_FFFC, 32'h0, 32'h0, 0);
        v[19] = mk(0, 0, 0, 0, 32'h0, 32'h0, 32'h4000_0000, 1);
        v[20] = mk(0, 0, 0, 0, 32'h4, 32'h4, 32'd1, 1);

        #2;
        chk_all("reset", 32'h0, 32'h0, 32'h0, 0);
`ifdef IF_PERF_CNT_EN
        chk("reset fetch_cnt", fetch_cnt, 32'd0);
        chk("reset stall_cnt", stall_cnt, 32'd0);
`endif
        @(negedge clk);
        rst = 1'b0;

        for (int i = 0; i < 21; i++) begin
            freeze = v[i].frz;
            branch_taken = v[i].br;
            branch_addr = v[i].baddr;
            flush = v[i].fl;
            @(posedge clk);
            #1;
            chk_all($sformatf("vec%0d", i), v[i].e_addr, v[i].e_pc, v[i].e_instr, v[i].e_valid);
`ifdef IF_PERF_CNT_EN
            if (i == 4)
                chk("stall_cnt after 3 freezes", stall_cnt, 32'd3);
`endif
        end
`ifdef IF_PERF_CNT_EN
        chk("fetch_cnt end", fetch_cnt, 32'd12);
        chk("stall_cnt end", stall_cnt, 32'd4);
`endif

        // Pulse reset between clock edges while freeze is held.
        freeze = 1'b1;
        branch_taken = 1'b0;
        flush = 1'b0;
        @(negedge clk);
        #1 rst = 1'b1;
        #1;
        chk_all("async rst", 32'h0, 32'h0, 32'h0, 0);
`ifdef IF_PERF_CNT_EN
        chk("async rst fetch_cnt", fetch_cnt, 32'd0);
        chk("async rst stall_cnt", stall_cnt, 32'd0);
`endif
        #1 rst = 1'b0;
        @(posedge clk);
        #1;
        chk_all("post-rst freeze", 32'h0, 32'h0, 32'h0, 0);
        freeze = 1'b0;
        @(posedge clk);
        #1;
        chk_all("restart", 32'h4, 32'h4, 32'd1, 1);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
